// File: rtl/mod17_result_fifo.sv
// FWFT result FIFO behind the divident_mod17 pipeline; overflow drops words and counts them.
// Optional build macro MOD17_RANGE_CHECK_EN adds range_err and rejects remainders above 16.
module mod17_result_fifo #(
    parameter int DEPTH  = 16,
    parameter int AW     = 4,
    parameter int DROP_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mark_in,
    input  logic [4:0]        reminder_in,
    output logic              out_valid,
    output logic [4:0]        out_data,
    input  logic              out_ready,
    output logic [AW:0]       level,
    output logic              full,
    output logic              empty,
    output logic              overflow,
    output logic [DROP_W-1:0] drop_cnt,
    input  logic              ovf_clr
`ifdef MOD17_RANGE_CHECK_EN
    ,
    output logic              range_err
`endif
);

    localparam logic [AW:0]       FULL_LEVEL = (AW+1)'(DEPTH);
    localparam logic [AW:0]       ONE_LEVEL  = (AW+1)'(1);
    localparam logic [DROP_W-1:0] DROP_MAX   = '1;
    localparam logic [DROP_W-1:0] DROP_ONE   = DROP_W'(1);

    logic [4:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          strobe;
    logic          push;
    logic          pop;
    logic          drop;
    logic [AW:0]   level_next;

`ifdef MOD17_RANGE_CHECK_EN
    logic bad_value;
    assign bad_value = reminder_in > 5'd16;
    assign strobe    = mark_in && !bad_value;
`else
    assign strobe    = mark_in;
`endif

    // A full FIFO may still take a word when the head leaves in the same cycle.
    assign pop  = out_valid && out_ready;
    assign push = strobe && (!full || pop);
    assign drop = strobe && full && !pop;

    always_comb begin
        level_next = level;
        case ({push, pop})
            2'b10:   level_next = level + ONE_LEVEL;
            2'b01:   level_next = level - ONE_LEVEL;
            default: level_next = level;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            full      <= 1'b0;
            empty     <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            level     <= level_next;
            full      <= (level_next == FULL_LEVEL);
            empty     <= (level_next == '0);
            out_valid <= (level_next != '0);
        end
    end

    // Storage is not reset; the head is read combinationally so it falls through.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= reminder_in;
    end

    assign out_data = mem[rd_ptr];

    // A drop coinciding with a clear leaves a count of exactly one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (ovf_clr)
                drop_cnt <= DROP_ONE;
            else if (drop_cnt != DROP_MAX)
                drop_cnt <= drop_cnt + DROP_ONE;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end
    end

`ifdef MOD17_RANGE_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) range_err <= 1'b0;
        else     range_err <= mark_in && bad_value;
    end
`endif

endmodule
